// File: rtl/alu_muldiv_seq.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One bit per cycle (shift-add multiply, restoring divide) with fixed latency:
// out_valid rises WIDTH+1 edges after the accept edge, regardless of operands.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | WIDTH iterations of shift-add / restoring divide
// FIX   | sign correction and result selection
// DONE  | result presented, held until out_ready

module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       S,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               neg_q;
  logic               neg_r;
  logic               dz_q;

  logic               accept;
  logic               x_sgn, y_sgn, x_neg, y_neg;
  logic [WIDTH-1:0]   x_mag_in, y_mag_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_sel;

  assign accept    = (state_q == IDLE) && in_valid && !flush;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (cnt == LAST_ITER) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Operand signedness and magnitudes at accept; S[2] selects divide,
  // MULHSU treats Y as unsigned, DIVU/REMU have S[0] set
  always_comb begin
    x_sgn    = S[2] ? !S[0] : (S[1:0] == 2'b01 || S[1:0] == 2'b10);
    y_sgn    = S[2] ? !S[0] : (S[1:0] == 2'b01);
    x_neg    = x_sgn && X[WIDTH-1];
    y_neg    = y_sgn && Y[WIDTH-1];
    x_mag_in = x_neg ? (~X + 1'b1) : X;
    y_mag_in = y_neg ? (~Y + 1'b1) : Y;
  end

  // One iteration of each algorithm, plus the sign-corrected final values
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    prod_fix  = neg_q ? (~prod + 1'b1) : prod;
    quo_fix   = neg_q ? (~quo + 1'b1) : quo;
    rem_fix   = neg_r ? (~rem + 1'b1) : rem;
    if (!op_q[2])
      res_sel = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else if (dz_q)
      res_sel = op_q[1] ? x_q : '1;
    else
      res_sel = op_q[1] ? rem_fix : quo_fix;
  end

  // Datapath: operand capture, iteration, result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      x_q      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        op_q  <= S;
        x_q   <= X;
        a_mag <= x_mag_in;
        b_mag <= y_mag_in;
        prod  <= {{WIDTH{1'b0}}, y_mag_in};
        rem   <= '0;
        quo   <= x_mag_in;
        neg_q <= x_neg ^ y_neg;
        neg_r <= x_neg;
        dz_q  <= S[2] && (Y == '0);
      end else if (state_q == CALC && !flush) begin
        cnt <= cnt + 1'b1;
        if (op_q[2]) begin
          if (!div_diff[WIDTH]) begin
            rem <= div_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end else begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
        end
      end else if (state_q == FIX && !flush) begin
        result   <= res_sel;
        div_zero <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq at WIDTH=32.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X, Y;
  logic [2:0]  S;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .S(S), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; X = '0; Y = '0; S = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || div_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got ov=%b busy=%b res=%h dz=%b want 0/0/0/0",
               out_valid, busy, result, div_zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // Issues one op, checks latency, result and div_zero, then consumes it
  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input logic exp_dz);
    int lat;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_idle: got %b want 1", nm, in_ready);
    end
    X = a; Y = b; S = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; X = $urandom; Y = $urandom; S = 3'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != 33) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges want 33", nm, lat);
    end
    n_cmp++;
    if (result !== exp_r) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", nm, result, exp_r);
    end
    n_cmp++;
    if (div_zero !== exp_dz) begin
      n_err++;
      $display("FAIL %s div_zero: got %b want %b", nm, div_zero, exp_dz);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s consume: got ov=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_mul();
    do_op("mul_11x3",      OP_MUL,    32'd11,        32'd3,         32'd33,        1'b0);
    do_op("mul_neg3x5",    OP_MUL,    32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  1'b0);
    do_op("mulhu_max",     OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0);
    do_op("mulhu_2pow33",  OP_MULHU,  32'h80000000,  32'd4,         32'h00000002,  1'b0);
    do_op("mulh_m1xm1",    OP_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  1'b0);
    do_op("mulhsu_m1x2",   OP_MULHSU, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  1'b0);
  endtask

  task automatic test_div();
    do_op("div_m7_2",      OP_DIV,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0);
    do_op("rem_m7_2",      OP_REM,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0);
    do_op("divu_9_9",      OP_DIVU,   32'd9,         32'd9,         32'd1,         1'b0);
    do_op("remu_100_7",    OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0);
  endtask

  task automatic test_div_corner();
    do_op("divu_by0",      OP_DIVU,   32'd9,         32'd0,         32'hFFFFFFFF,  1'b1);
    do_op("remu_by0",      OP_REMU,   32'd9,         32'd0,         32'd9,         1'b1);
    do_op("div_by0_neg",   OP_DIV,    32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  1'b1);
    do_op("rem_by0_neg",   OP_REM,    32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  1'b1);
    do_op("div_ovf",       OP_DIV,    32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0);
    do_op("rem_ovf",       OP_REM,    32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1'b0);
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  bad;
    X = 32'd6; Y = 32'd7; S = OP_MUL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    bad = (lat >= 100);
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd42) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad || out_valid !== 1'b1 || result !== 32'd42) begin
      n_err++;
      $display("FAIL backpressure_hold: got ov=%b in_ready=%b res=%h want 1/0/0000002a",
               out_valid, in_ready, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: got ov=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    X = 32'd123; Y = 32'd456; S = OP_MULHU; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midop_busy_before: got %b want 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midop_async_reset: got ov=%b busy=%b want 0/0", out_valid, busy);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    bit seen;
    X = 32'd77; Y = 32'd3; S = OP_DIVU; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_calc: got busy=%b in_ready=%b ov=%b want 0/1/0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL flush_no_result: got out_valid rising want none");
    end
    // flush beats in_valid in IDLE
    X = 32'd1; Y = 32'd1; S = OP_MUL; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_accept: got busy=%b want 0", busy);
    end
    do_op("mul_5x7_after_flush", OP_MUL, 32'd5, 32'd7, 32'd35, 1'b0);
    // flush beats out_ready in DONE
    X = 32'd2; Y = 32'd2; S = OP_MUL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_done_pre: got ov=%b want 1", out_valid);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_done: got ov=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_corner();
    test_backpressure();
    test_reset_mid_op();
    test_flush();
    do_op("mul_after_all", OP_MUL, 32'd1000, 32'd1000, 32'd1000000, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
